// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: choice codes, hazard FSM states, control bundle.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package pipe_pkg;

    // Pipeline-register choice codes. 2'b11 is never driven.
    localparam logic [1:0] CH_FLUSH = 2'b00;
    localparam logic [1:0] CH_LOAD  = 2'b01;
    localparam logic [1:0] CH_HOLD  = 2'b10;

    // Hazard controller state encoding.
    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MD_WAIT = 2'd2
    } hz_state_t;

    // One cycle's worth of pipeline control.
    typedef struct packed {
        logic [1:0] ifid;
        logic [1:0] idex;
        logic [1:0] exmem;
        logic [1:0] memwb;
        logic       pc_en;
    } hz_ctl_t;

    // Build a control bundle from its fields.
    function automatic hz_ctl_t mk_ctl(input logic [1:0] ifid,
                                       input logic [1:0] idex,
                                       input logic [1:0] exmem,
                                       input logic [1:0] memwb,
                                       input logic       pc_en);
        hz_ctl_t c;
        c.ifid  = ifid;
        c.idex  = idex;
        c.exmem = exmem;
        c.memwb = memwb;
        c.pc_en = pc_en;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID source specifiers and the EX load destination.
// Latency: purely combinational, same cycle.
// Backpressure: none; o_stall is consumed by the hazard FSM in the same cycle.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic             o_stall
);

    logic w_rd_nonzero;
    logic w_rs_hit;
    logic w_rt_hit;

    // A load to $zero never produces a value worth waiting for.
    always_comb begin
        w_rd_nonzero = (i_ex_rd != '0);
        w_rs_hit     = i_id_use_rs && (i_id_rs == i_ex_rd);
        w_rt_hit     = i_id_use_rt && (i_id_rt == i_ex_rd);
        o_stall      = i_ex_mem_read && w_rd_nonzero && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-register choice codes and PC enable for the 5-stage core.
// Latency: outputs combinational from registered state + inputs; state/counters update on clk.
// Backpressure: stalls fetch/decode via HOLD codes and pc_en=0 on load-use and mul/div waits.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_id_jump,
    input  logic             i_ex_br_taken,
    input  logic             i_ex_md_start,
    input  logic             i_exc_req,
    output logic [1:0]       o_ch_ifid,
    output logic [1:0]       o_ch_idex,
    output logic [1:0]       o_ch_exmem,
    output logic [1:0]       o_ch_memwb,
    output logic             o_pc_en,
    output logic             o_md_busy,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Hold cycles after the start cycle; the start cycle itself is the first EX hold.
    localparam logic [3:0] MD_RELOAD = 4'(MD_LAT - 2);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [3:0]       r_md_cnt;
    logic [3:0]       w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;
    hz_ctl_t          w_run_ctl;
    hz_ctl_t          w_ctl;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_use_rs   (i_id_use_rs),
        .i_id_use_rt   (i_id_use_rt),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .o_stall       (w_load_use)
    );

    // RUN-mode priority: exception > taken branch > load-use > jump > normal flow.
    always_comb begin
        w_run_ctl = mk_ctl(CH_LOAD, CH_LOAD, CH_LOAD, CH_LOAD, 1'b1);
        if (i_exc_req) begin
            w_run_ctl = mk_ctl(CH_FLUSH, CH_FLUSH, CH_FLUSH, CH_FLUSH, 1'b1);
        end else if (i_ex_br_taken) begin
            w_run_ctl = mk_ctl(CH_FLUSH, CH_FLUSH, CH_LOAD, CH_LOAD, 1'b1);
        end else if (w_load_use) begin
            // The younger jump (if any) stays in IF/ID and is retaken next cycle.
            w_run_ctl = mk_ctl(CH_HOLD, CH_FLUSH, CH_LOAD, CH_LOAD, 1'b0);
        end else if (i_id_jump) begin
            w_run_ctl = mk_ctl(CH_FLUSH, CH_LOAD, CH_LOAD, CH_LOAD, 1'b1);
        end
    end

    // Next-state, md counter reload/decrement and output selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_ctl        = mk_ctl(CH_FLUSH, CH_FLUSH, CH_FLUSH, CH_FLUSH, 1'b0);
        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_ctl = w_run_ctl;
                if (i_ex_md_start && !i_exc_req) begin
                    w_state_nxt  = ST_MD_WAIT;
                    w_md_cnt_nxt = MD_RELOAD;
                end
            end
            ST_MD_WAIT: begin
                if (i_exc_req) begin
                    // Abort the wait; the exception flush takes the pipe.
                    w_ctl        = w_run_ctl;
                    w_md_cnt_nxt = 4'd0;
                    w_state_nxt  = ST_RUN;
                end else if (r_md_cnt != 4'd0) begin
                    w_ctl        = mk_ctl(CH_HOLD, CH_HOLD, CH_FLUSH, CH_LOAD, 1'b0);
                    w_md_cnt_nxt = r_md_cnt - 4'd1;
                end else begin
                    // Release cycle: result is ready, behave as normal RUN.
                    w_ctl       = w_run_ctl;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt  = ST_INIT;
                w_md_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State and md counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_INIT;
            r_md_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Saturating count of stalled fetch cycles; the INIT cycle is not a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state != ST_INIT) && !w_ctl.pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Drive the per-register codes and status outputs.
    always_comb begin
        o_ch_ifid   = w_ctl.ifid;
        o_ch_idex   = w_ctl.idex;
        o_ch_exmem  = w_ctl.exmem;
        o_ch_memwb  = w_ctl.memwb;
        o_pc_en     = w_ctl.pc_en;
        o_md_busy   = (r_state == ST_MD_WAIT);
        o_stall_cnt = r_stall_cnt;
    end

endmodule
